main_mem_ctrl: RTL
==================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 3, access wait cycles before first data/commit; legal range 1..15.
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, words per refill burst; 16-byte block.
REQ-003 SHALL have parameter DEPTH_WORDS, default 256, backing array size in 32-bit words, covering a 10-bit byte address.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  cache request present.
REQ-007 req_write  in  1  1 = single-word write-through, 0 = block refill read.
REQ-008 req_addr  in  10  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 req_storetype  in  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-011 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-012 rsp_valid  out  1  refill beat valid.
REQ-013 rsp_data  out  32  refill beat data.
REQ-014 rsp_idx  out  2  word index within the block for the current beat.
REQ-015 rsp_last  out  1  final beat of the burst.
REQ-016 wr_done  out  1  one-cycle pulse: write committed.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, BURST, COMMIT; req_ready = 1 only in IDLE.
REQ-018 Acceptance (cycle 0) SHALL latch addr/wdata/storetype/write and enter WAIT; latched values are immune to later input changes.
REQ-019 WAIT SHALL last exactly LATENCY cycles via down-counter, then go to BURST (read) or COMMIT (write).
REQ-020 BURST SHALL assert rsp_valid on BLOCK_WORDS consecutive cycles (cycles LATENCY+1..LATENCY+BLOCK_WORDS), no gaps, no back-pressure.
REQ-021 Beat word address SHALL be {req_addr[9:4], rsp_idx}; rsp_idx increments modulo BLOCK_WORDS.
REQ-022 rsp_last SHALL be high only with the final beat; the next cycle is IDLE.
REQ-023 COMMIT SHALL last one cycle (cycle LATENCY+1), pulse wr_done, and update the array at that edge; next cycle is IDLE.
REQ-024 Byte write SHALL update lane req_addr[1:0] with wdata[7:0]; half SHALL update lanes {addr[1],0}/{addr[1],1} with wdata[15:0]; word SHALL update all lanes at word addr[9:2]; addr[0]/addr[1:0] ignored for half/word.
REQ-025 Minimum spacing: a new request SHALL be accepted no earlier than the cycle after rsp_last or wr_done.
REQ-026 req_valid in a non-IDLE state SHALL be ignored (not queued).
REQ-027 rsp_data, rsp_idx SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-028 rst low SHALL immediately force IDLE, counter 0, req_ready 1, rsp_valid/rsp_last/wr_done 0, rsp_data 0, rsp_idx 0.
REQ-029 Array contents SHALL NOT be reset; a write aborted by reset before its COMMIT edge SHALL leave memory unchanged.
REQ-030 A refill aborted mid-burst SHALL emit no further beats; the cache must reissue.

Configuration
REQ-031 Macro MAIN_MEM_WRAP_BURST_EN defined: burst SHALL start at critical word req_addr[3:2] and wrap within the block (e.g. 2,3,0,1).
REQ-032 Macro undefined: burst SHALL always start at rsp_idx 0 (0,1,2,3); req_addr[3:2] ignored for reads.

Verification
REQ-033 Preload word 0x40..0x4C = 11,22,33,44; read req_addr=0x048 at cycle 0, LATENCY=3 -> beats cycles 4-7; undefined macro: idx 0,1,2,3 data 11,22,33,44, rsp_last at cycle 7; defined: idx 2,3,0,1 data 33,44,11,22.
REQ-034 Word 0x10 = 0xAABBCCDD; byte write addr 0x012 data 0x55 -> wr_done at cycle 4; refill shows 0xAA55CCDD.
REQ-035 Half write addr 0x016 data 0x1234 over 0x00000000 -> word 0x14 = 0x12340000; storetype 11 word write 0xDEADBEEF -> full word replaced.
REQ-036 Assert rst low at cycle 2 of a write (WAIT) -> wr_done never pulses, target word unchanged, req_ready = 1 immediately.
REQ-037 Hold req_valid high continuously across two reads -> second accepted the cycle after first rsp_last; requests during WAIT/BURST ignored; rsp_data = 0 between bursts.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// Main-memory model/controller: serves block refills and write-through stores for a cache.
// Define MAIN_MEM_WRAP_BURST_EN to start refills at the critical word and wrap; default is in-order.
module main_mem_ctrl #(
  parameter int LATENCY     = 3,
  parameter int BLOCK_WORDS = 4,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_storetype,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_idx,
  output logic        rsp_last,
  output logic        wr_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] BURST  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [9:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    stype_q;
  logic          write_q;
  logic [1:0]    idx;
  logic [BW-1:0] beat;
  logic [1:0]    start_idx;
  logic [1:0]    next_idx;
  logic          last_beat;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef MAIN_MEM_WRAP_BURST_EN
  assign start_idx = addr_q[3:2];
`else
  assign start_idx = 2'd0;
`endif

  assign next_idx  = (idx == 2'(BLOCK_WORDS - 1)) ? 2'd0 : idx + 2'd1;
  assign last_beat = (beat == BW'(BLOCK_WORDS - 1));
  assign raddr     = AW'({addr_q[9:4], idx});
  assign waddr     = AW'(addr_q[9:2]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      stype_q <= '0;
      write_q <= 1'b0;
      idx     <= '0;
      beat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            stype_q <= req_storetype;
            write_q <= req_write;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= write_q ? COMMIT : BURST;
            idx   <= start_idx;
            beat  <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        BURST: begin
          if (last_beat) begin
            state <= IDLE;
            idx   <= '0;
            beat  <= '0;
          end else begin
            idx  <= next_idx;
            beat <= beat + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane enables and lane-replicated data for the committed store.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (stype_q)
      2'b10: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  // NOTE: the array has no reset; a reset before COMMIT simply never reaches this write.
  always_ff @(posedge clk) begin
    if (state == COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == BURST);
  assign rsp_data  = rsp_valid ? mem[raddr] : 32'd0;
  assign rsp_idx   = rsp_valid ? idx : 2'd0;
  assign rsp_last  = rsp_valid && last_beat;
  assign wr_done   = (state == COMMIT);

endmodule
